// File: rtl/cpu_datapath_if.sv
// rtl/cpu_datapath_if.sv - memory_port and datapath_control interfaces for cpu_datapath
// Optional feature macro: DATAPATH_MISALIGN_CHECK_EN (adds datapath_control.misaligned).
// memory_port:      addr, wdata, wstrb, we, re driven by master; rdata returned by slave.
// datapath_control: control strobes driven by the FSM (master); decode fields and
//                   compare flags returned by the datapath (slave).
interface memory_port;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        we;
   logic        re;
   logic [31:0] rdata;

   modport master (output addr, output wdata, output wstrb, output we, output re,
                   input rdata);
   modport slave  (input addr, input wdata, input wstrb, input we, input re,
                   output rdata);
endinterface

interface datapath_control;
   logic       pc_we;
   logic [1:0] pc_sel;
   logic       ir_we;
   logic       rf_we;
   logic [1:0] wb_sel;
   logic       alu_a_sel;
   logic       alu_b_sel;
   logic [3:0] alu_op;
   logic       mem_addr_sel;
   logic       mem_re;
   logic       mem_we;
   logic [1:0] mem_size;
   logic       load_unsigned;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       cmp_eq;
   logic       cmp_lt;
   logic       cmp_ltu;
`ifdef DATAPATH_MISALIGN_CHECK_EN
   logic       misaligned;
`endif

   modport master (
`ifdef DATAPATH_MISALIGN_CHECK_EN
      input  misaligned,
`endif
      output pc_we, output pc_sel, output ir_we, output rf_we, output wb_sel,
      output alu_a_sel, output alu_b_sel, output alu_op, output mem_addr_sel,
      output mem_re, output mem_we, output mem_size, output load_unsigned,
      input  opcode, input funct3, input funct7,
      input  cmp_eq, input cmp_lt, input cmp_ltu
   );

   modport slave (
`ifdef DATAPATH_MISALIGN_CHECK_EN
      output misaligned,
`endif
      input  pc_we, input pc_sel, input ir_we, input rf_we, input wb_sel,
      input  alu_a_sel, input alu_b_sel, input alu_op, input mem_addr_sel,
      input  mem_re, input mem_we, input mem_size, input load_unsigned,
      output opcode, output funct3, output funct7,
      output cmp_eq, output cmp_lt, output cmp_ltu
   );
endinterface

// File: rtl/cpu_datapath.sv
// rtl/cpu_datapath.sv - multicycle RV32I integer datapath driven by an external control FSM
// Optional feature macro: DATAPATH_MISALIGN_CHECK_EN (misaligned flag, misaligned stores blocked).
// Ports:
//   clk      core clock, all state updates on the rising edge
//   rst_n    asynchronous active-low reset
//   mem_port memory_port.master: addr/wdata/wstrb/we/re out, rdata in
//   control  datapath_control.slave: control strobes in; opcode/funct3/funct7,
//            cmp_eq/cmp_lt/cmp_ltu (and misaligned when enabled) out
module cpu_datapath #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic           clk,
   input  logic           rst_n,
   memory_port.master     mem_port,
   datapath_control.slave control
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_ir;
   logic [XLEN-1:0] r_rf [32];
   logic [1:0]      r_addr_lo;

   logic [4:0]      w_rs1_idx, w_rs2_idx, w_rd_idx;
   logic [XLEN-1:0] w_rs1, w_rs2, w_imm;
   logic [XLEN-1:0] w_alu_a, w_alu_b, w_alu_result;
   logic [4:0]      w_shamt;
   logic [XLEN-1:0] w_pc_plus4, w_pc_next, w_wb_data, w_mem_addr;
   logic [7:0]      w_ld_byte;
   logic [15:0]     w_ld_half;
   logic [XLEN-1:0] w_load_data, w_wdata;
   logic [3:0]      w_wstrb;
   logic            w_store_ok;

   // Decode
   assign control.opcode = r_ir[6:0];
   assign control.funct3 = r_ir[14:12];
   assign control.funct7 = r_ir[31:25];
   assign w_rs1_idx      = r_ir[19:15];
   assign w_rs2_idx      = r_ir[24:20];
   assign w_rd_idx       = r_ir[11:7];

   // Register file reads; reads see the pre-edge contents during a write cycle
   assign w_rs1 = (w_rs1_idx == 5'd0) ? '0 : r_rf[w_rs1_idx];
   assign w_rs2 = (w_rs2_idx == 5'd0) ? '0 : r_rf[w_rs2_idx];

   // Immediate generator, format chosen from the opcode
   always_comb begin
      w_imm = '0;
      case (r_ir[6:0])
         OP_LOAD, OP_IMM, OP_JALR: w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
         OP_STORE:                 w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
         OP_BRANCH:                w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7],
                                            r_ir[30:25], r_ir[11:8], 1'b0};
         OP_LUI, OP_AUIPC:         w_imm = {r_ir[31:12], 12'd0};
         OP_JAL:                   w_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12],
                                            r_ir[20], r_ir[30:21], 1'b0};
         default:                  w_imm = '0;
      endcase
   end

   // ALU
   assign w_alu_a = control.alu_a_sel ? r_pc : w_rs1;
   assign w_alu_b = control.alu_b_sel ? w_imm : w_rs2;
   assign w_shamt = w_alu_b[4:0];

   always_comb begin
      w_alu_result = '0;
      case (control.alu_op)
         4'd0:    w_alu_result = w_alu_a + w_alu_b;
         4'd1:    w_alu_result = w_alu_a - w_alu_b;
         4'd2:    w_alu_result = w_alu_a << w_shamt;
         4'd3:    w_alu_result = {{(XLEN-1){1'b0}}, $signed(w_alu_a) < $signed(w_alu_b)};
         4'd4:    w_alu_result = {{(XLEN-1){1'b0}}, w_alu_a < w_alu_b};
         4'd5:    w_alu_result = w_alu_a ^ w_alu_b;
         4'd6:    w_alu_result = w_alu_a >> w_shamt;
         4'd7:    w_alu_result = $signed(w_alu_a) >>> w_shamt;
         4'd8:    w_alu_result = w_alu_a | w_alu_b;
         4'd9:    w_alu_result = w_alu_a & w_alu_b;
         4'd10:   w_alu_result = w_alu_b;
         default: w_alu_result = '0;
      endcase
   end

   // Branch comparator, always on rs1 vs rs2
   assign control.cmp_eq  = (w_rs1 == w_rs2);
   assign control.cmp_lt  = ($signed(w_rs1) < $signed(w_rs2));
   assign control.cmp_ltu = (w_rs1 < w_rs2);

   // Next PC
   assign w_pc_plus4 = r_pc + 32'd4;

   always_comb begin
      w_pc_next = w_pc_plus4;
      case (control.pc_sel)
         2'd0: w_pc_next = w_pc_plus4;
         2'd1: w_pc_next = w_alu_result;
         2'd2: w_pc_next = w_alu_result & ~32'd1;
         2'd3: w_pc_next = r_pc + w_imm;
      endcase
   end

   // Load alignment uses the address bits captured when the read was issued
   always_comb begin
      w_ld_byte = mem_port.rdata[7:0];
      case (r_addr_lo)
         2'd0: w_ld_byte = mem_port.rdata[7:0];
         2'd1: w_ld_byte = mem_port.rdata[15:8];
         2'd2: w_ld_byte = mem_port.rdata[23:16];
         2'd3: w_ld_byte = mem_port.rdata[31:24];
      endcase
   end

   assign w_ld_half = r_addr_lo[1] ? mem_port.rdata[31:16] : mem_port.rdata[15:0];

   always_comb begin
      w_load_data = mem_port.rdata;
      case (control.mem_size)
         2'd0:    w_load_data = control.load_unsigned ? {24'd0, w_ld_byte}
                                                      : {{24{w_ld_byte[7]}}, w_ld_byte};
         2'd1:    w_load_data = control.load_unsigned ? {16'd0, w_ld_half}
                                                      : {{16{w_ld_half[15]}}, w_ld_half};
         default: w_load_data = mem_port.rdata;
      endcase
   end

   // Write-back; pc+4 is formed from the pre-edge pc even when pc_we is set
   always_comb begin
      w_wb_data = w_alu_result;
      case (control.wb_sel)
         2'd0: w_wb_data = w_alu_result;
         2'd1: w_wb_data = w_load_data;
         2'd2: w_wb_data = w_pc_plus4;
         2'd3: w_wb_data = w_imm;
      endcase
   end

   // Memory address, store lanes and byte strobes
   assign w_mem_addr = control.mem_addr_sel ? w_alu_result : r_pc;

   always_comb begin
      w_wdata = w_rs2;
      w_wstrb = 4'hF;
      case (control.mem_size)
         2'd0: begin
            w_wdata = {4{w_rs2[7:0]}};
            w_wstrb = 4'b0001 << w_mem_addr[1:0];
         end
         2'd1: begin
            w_wdata = {2{w_rs2[15:0]}};
            w_wstrb = 4'b0011 << {w_mem_addr[1], 1'b0};
         end
         default: begin
            w_wdata = w_rs2;
            w_wstrb = 4'hF;
         end
      endcase
   end

`ifdef DATAPATH_MISALIGN_CHECK_EN
   logic w_access_misaligned;

   always_comb begin
      w_access_misaligned = 1'b0;
      case (control.mem_size)
         2'd0:    w_access_misaligned = 1'b0;
         2'd1:    w_access_misaligned = w_mem_addr[0];
         default: w_access_misaligned = |w_mem_addr[1:0];
      endcase
   end

   assign control.misaligned = ((control.mem_re | control.mem_we) & w_access_misaligned)
                             | (control.pc_we & (|w_pc_next[1:0]));
   assign w_store_ok = ~w_access_misaligned;
`else
   assign w_store_ok = 1'b1;
`endif

   assign mem_port.addr  = w_mem_addr;
   assign mem_port.wdata = w_wdata;
   assign mem_port.re    = control.mem_re;
   assign mem_port.we    = control.mem_we & w_store_ok;
   assign mem_port.wstrb = (control.mem_we & w_store_ok) ? w_wstrb : 4'h0;

   // State
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc      <= RESET_PC;
         r_ir      <= NOP_INSTR;
         r_addr_lo <= 2'd0;
      end else begin
         if (control.pc_we)  r_pc      <= w_pc_next;
         if (control.ir_we)  r_ir      <= mem_port.rdata;
         if (control.mem_re) r_addr_lo <= w_mem_addr[1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) r_rf[i] <= '0;
      end else if (control.rf_we && (w_rd_idx != 5'd0)) begin
         r_rf[w_rd_idx] <= w_wb_data;
      end
   end

endmodule

// File: tb/tb_cpu_datapath.sv
// tb/tb_cpu_datapath.sv - self-checking bench for cpu_datapath
module tb_cpu_datapath;

   localparam logic [6:0] OPC_OP    = 7'h33;
   localparam logic [6:0] OPC_IMM   = 7'h13;
   localparam logic [6:0] OPC_LOAD  = 7'h03;
   localparam logic [6:0] OPC_STORE = 7'h23;
   localparam logic [6:0] OPC_JALR  = 7'h67;
   localparam logic [6:0] OPC_BR    = 7'h63;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   logic [31:0] model_rf [32];

   memory_port      mem_if ();
   datapath_control ctl_if ();

   cpu_datapath dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mem_port (mem_if),
      .control  (ctl_if)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } alu_vec_t;

   alu_vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic idle();
      ctl_if.pc_we = 0; ctl_if.pc_sel = 0; ctl_if.ir_we = 0; ctl_if.rf_we = 0;
      ctl_if.wb_sel = 0; ctl_if.alu_a_sel = 0; ctl_if.alu_b_sel = 0; ctl_if.alu_op = 0;
      ctl_if.mem_addr_sel = 0; ctl_if.mem_re = 0; ctl_if.mem_we = 0; ctl_if.mem_size = 0;
      ctl_if.load_unsigned = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
   endtask

   task automatic model_write(input int n, input logic [31:0] v);
      if (n != 0) model_rf[n] = v;
   endtask

   task automatic load_ir(input logic [31:0] instr);
      idle();
      mem_if.rdata = instr;
      ctl_if.ir_we = 1;
      tick();
      idle();
   endtask

   // Writes a register through the word-load path (pc is kept word aligned)
   task automatic set_reg(input int n, input logic [31:0] val);
      load_ir({12'd0, 5'd0, 3'b010, 5'(n), OPC_LOAD});
      ctl_if.mem_re = 1;
      tick();
      idle();
      mem_if.rdata = val;
      ctl_if.rf_we = 1; ctl_if.wb_sel = 2'd1; ctl_if.mem_size = 2'd2;
      tick();
      idle();
      model_write(n, val);
   endtask

   // Observes a register as rs2 of a word store
   task automatic check_reg(input string name, input int n, input logic [31:0] exp);
      load_ir({7'd0, 5'(n), 5'd0, 3'b010, 5'd0, OPC_STORE});
      ctl_if.mem_we = 1; ctl_if.mem_size = 2'd2;
      settle();
      check(name, mem_if.wdata, exp);
      idle();
   endtask

   task automatic do_load(input logic [31:0] instr, input logic [31:0] rdata,
                          input logic [1:0] size, input logic uns);
      load_ir(instr);
      ctl_if.alu_b_sel = 1; ctl_if.mem_addr_sel = 1; ctl_if.mem_re = 1;
      tick();
      idle();
      mem_if.rdata = rdata;
      ctl_if.rf_we = 1; ctl_if.wb_sel = 2'd1; ctl_if.mem_size = size;
      ctl_if.load_unsigned = uns;
      tick();
      idle();
   endtask

   task automatic exec_alu(input logic [3:0] op, input logic bsel);
      ctl_if.alu_op = op; ctl_if.alu_b_sel = bsel; ctl_if.rf_we = 1; ctl_if.wb_sel = 2'd0;
      tick();
      idle();
   endtask

   function automatic logic [31:0] sext12(input logic [11:0] v);
      return (v >= 12'h800) ? (32'(v) | 32'hFFFF_F000) : 32'(v);
   endfunction

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int sa, sb;
      logic [31:0] r;
      sa = a;
      sb = b;
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a << (b % 32);
         4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
         4'd4:  return (a < b) ? 32'd1 : 32'd0;
         4'd5:  return a ^ b;
         4'd6:  return a >> (b % 32);
         4'd7:  begin
            r = a >> (b % 32);
            if (a[31]) r = r | ~(32'hFFFF_FFFF >> (b % 32));
            return r;
         end
         4'd8:  return a | b;
         4'd9:  return a & b;
         4'd10: return b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int lo,
                                            input int size, input bit uns);
      logic [31:0] v;
      if (size == 0) begin
         v = (rdata >> (8 * lo)) & 32'hFF;
         if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (size == 1) begin
         v = (rdata >> (8 * lo)) & 32'hFFFF;
         if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
         v = rdata;
      end
      return v;
   endfunction

   initial begin
      logic [31:0] instr, a, b, val, rdata, exp, wexp;
      logic [11:0] imm12;
      logic [3:0]  op, sexp;
      logic [2:0]  f3;
      int          rs1, rs2, rd, lo, size;
      bit          bsel, uns;

      vecs[0]  = '{op: 4'd0,  a: 32'h7FFF_FFFF, b: 32'h0000_0001, exp: 32'h8000_0000};
      vecs[1]  = '{op: 4'd1,  a: 32'h0000_0000, b: 32'h0000_0001, exp: 32'hFFFF_FFFF};
      vecs[2]  = '{op: 4'd2,  a: 32'h0000_0001, b: 32'h0000_0021, exp: 32'h0000_0002};
      vecs[3]  = '{op: 4'd2,  a: 32'h8000_0001, b: 32'h0000_001F, exp: 32'h8000_0000};
      vecs[4]  = '{op: 4'd3,  a: 32'hFFFF_FFFF, b: 32'h0000_0001, exp: 32'h0000_0001};
      vecs[5]  = '{op: 4'd4,  a: 32'hFFFF_FFFF, b: 32'h0000_0001, exp: 32'h0000_0000};
      vecs[6]  = '{op: 4'd5,  a: 32'hF0F0_F0F0, b: 32'hFF00_FF00, exp: 32'h0FF0_0FF0};
      vecs[7]  = '{op: 4'd6,  a: 32'h8000_0000, b: 32'h0000_0004, exp: 32'h0800_0000};
      vecs[8]  = '{op: 4'd7,  a: 32'h8000_0000, b: 32'h0000_0004, exp: 32'hF800_0000};
      vecs[9]  = '{op: 4'd8,  a: 32'h1234_0000, b: 32'h0000_5678, exp: 32'h1234_5678};
      vecs[10] = '{op: 4'd9,  a: 32'hF0F0_F0F0, b: 32'hFF00_FF00, exp: 32'hF000_F000};
      vecs[11] = '{op: 4'd10, a: 32'h0000_1234, b: 32'hCAFE_BABE, exp: 32'hCAFE_BABE};
      vecs[12] = '{op: 4'd11, a: 32'h0000_0005, b: 32'h0000_0003, exp: 32'h0000_0000};
      vecs[13] = '{op: 4'd15, a: 32'h0000_0005, b: 32'h0000_0003, exp: 32'h0000_0000};

      // Reset
      idle();
      mem_if.rdata = 32'd0;
      model_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      settle();
      check("reset_pc", mem_if.addr, 32'h0);
      check("reset_opcode", 32'(ctl_if.opcode), 32'h13);
      check("reset_re", 32'(mem_if.re), 32'd0);
      check("reset_we", 32'(mem_if.we), 32'd0);
      check("reset_wstrb", 32'(mem_if.wstrb), 32'd0);

      // Fetch
      ctl_if.mem_re = 1;
      settle();
      check("fetch_re", 32'(mem_if.re), 32'd1);
      tick();
      idle();
      mem_if.rdata = 32'h007302B3;
      ctl_if.ir_we = 1; ctl_if.pc_we = 1; ctl_if.pc_sel = 2'd0;
      tick();
      idle();
      settle();
      check("fetch_opcode", 32'(ctl_if.opcode), 32'h33);
      check("fetch_funct3", 32'(ctl_if.funct3), 32'h0);
      check("fetch_funct7", 32'(ctl_if.funct7), 32'h0);
      check("fetch_pc", mem_if.addr, 32'h4);

      // ALU: x6=5, x7=7, add, sub
      load_ir({12'd5, 5'd0, 3'd0, 5'd6, OPC_IMM});
      exec_alu(4'd0, 1'b1);
      model_write(6, 32'd5);
      load_ir({12'd7, 5'd0, 3'd0, 5'd7, OPC_IMM});
      exec_alu(4'd0, 1'b1);
      model_write(7, 32'd7);
      load_ir(32'h007302B3);
      exec_alu(4'd0, 1'b0);
      model_write(5, 32'd12);
      check_reg("add_x5", 5, 32'd12);
      load_ir(32'h407302B3);
      settle();
      check("cmp_eq_5_7", 32'(ctl_if.cmp_eq), 32'd0);
      check("cmp_lt_5_7", 32'(ctl_if.cmp_lt), 32'd1);
      check("cmp_ltu_5_7", 32'(ctl_if.cmp_ltu), 32'd1);
      exec_alu(4'd1, 1'b0);
      model_write(5, 32'hFFFF_FFFE);
      check_reg("sub_x5", 5, 32'hFFFF_FFFE);

      // x0 stays zero
      load_ir({12'h055, 5'd0, 3'd0, 5'd0, OPC_IMM});
      ctl_if.alu_b_sel = 1; ctl_if.mem_addr_sel = 1;
      settle();
      check("x0_alu_result", mem_if.addr, 32'h55);
      exec_alu(4'd0, 1'b1);
      check_reg("x0_read", 0, 32'd0);

      // sb x7, 2(x1) and lb / lbu
      set_reg(7, 32'h0000_00A5);
      set_reg(1, 32'h0000_0100);
      load_ir({7'd0, 5'd7, 5'd1, 3'b000, 5'd2, OPC_STORE});
      ctl_if.alu_b_sel = 1; ctl_if.mem_addr_sel = 1; ctl_if.mem_we = 1; ctl_if.mem_size = 2'd0;
      settle();
      check("sb_addr", mem_if.addr, 32'h102);
      check("sb_wstrb", 32'(mem_if.wstrb), 32'b0100);
      check("sb_wdata", mem_if.wdata, 32'hA5A5_A5A5);
      check("sb_we", 32'(mem_if.we), 32'd1);
      idle();
      settle();
      check("idle_we", 32'(mem_if.we), 32'd0);
      check("idle_wstrb", 32'(mem_if.wstrb), 32'd0);
      do_load({12'd2, 5'd1, 3'b000, 5'd8, OPC_LOAD}, 32'h00A5_0000, 2'd0, 1'b0);
      model_write(8, 32'hFFFF_FFA5);
      check_reg("lb", 8, 32'hFFFF_FFA5);
      do_load({12'd2, 5'd1, 3'b100, 5'd8, OPC_LOAD}, 32'h00A5_0000, 2'd0, 1'b1);
      model_write(8, 32'h0000_00A5);
      check_reg("lbu", 8, 32'h0000_00A5);

      // jalr x9, 0(x1) from pc=0x20 with x1=0x101
      load_ir({12'h020, 5'd0, 3'd0, 5'd0, OPC_IMM});
      ctl_if.alu_b_sel = 1; ctl_if.alu_op = 4'd10; ctl_if.pc_we = 1; ctl_if.pc_sel = 2'd1;
      tick();
      idle();
      settle();
      check("pc_set_0x20", mem_if.addr, 32'h20);
      set_reg(1, 32'h0000_0101);
      load_ir({12'd0, 5'd1, 3'b000, 5'd9, OPC_JALR});
      ctl_if.alu_b_sel = 1; ctl_if.alu_op = 4'd0; ctl_if.pc_we = 1; ctl_if.pc_sel = 2'd2;
      ctl_if.rf_we = 1; ctl_if.wb_sel = 2'd2;
      tick();
      idle();
      settle();
      check("jalr_pc", mem_if.addr, 32'h100);
      model_write(9, 32'h24);
      check_reg("jalr_link", 9, 32'h24);

      // Branch target pc+imm with imm=-8
      load_ir({1'b1, 6'b111111, 5'd0, 5'd0, 3'b000, 4'b1100, 1'b1, OPC_BR});
      settle();
      check("beq_cmp_eq", 32'(ctl_if.cmp_eq), 32'd1);
      ctl_if.pc_we = 1; ctl_if.pc_sel = 2'd3;
      tick();
      idle();
      settle();
      check("branch_pc", mem_if.addr, 32'hF8);

      // Same-cycle read of the register being written returns the old value
      set_reg(3, 32'h0000_1111);
      load_ir({7'd0, 5'd3, 5'd0, 3'd0, 5'd3, OPC_OP});
      ctl_if.alu_op = 4'd10; ctl_if.alu_b_sel = 1; ctl_if.rf_we = 1; ctl_if.wb_sel = 2'd0;
      ctl_if.mem_we = 1; ctl_if.mem_size = 2'd2;
      settle();
      check("rf_read_old", mem_if.wdata, 32'h1111);
      tick();
      settle();
      check("rf_read_new", mem_if.wdata, 32'h0);
      idle();
      model_write(3, 32'h0);

      // Reset asserted mid-instruction
      set_reg(4, 32'hDEAD_BEEF);
      load_ir({12'h040, 5'd0, 3'd0, 5'd4, OPC_IMM});
      ctl_if.pc_we = 1; ctl_if.rf_we = 1; ctl_if.alu_b_sel = 1;
      settle();
      rst_n = 1'b0;
      #1;
      check("midreset_pc", mem_if.addr, 32'h0);
      check("midreset_opcode", 32'(ctl_if.opcode), 32'h13);
      idle();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      check_reg("midreset_x4", 4, 32'h0);
      check_reg("midreset_x9", 9, 32'h0);

      // Table-driven ALU vectors
      for (int i = 0; i < 14; i++) begin
         set_reg(1, vecs[i].a);
         set_reg(2, vecs[i].b);
         load_ir({7'd0, 5'd2, 5'd1, 3'd0, 5'd10, OPC_OP});
         ctl_if.alu_op = vecs[i].op; ctl_if.mem_addr_sel = 1;
         settle();
         check($sformatf("alu_vec%0d", i), mem_if.addr, vecs[i].exp);
         idle();
      end

      // Randomized ALU operations against the model
      for (int i = 0; i < 60; i++) begin
         rs1   = $urandom_range(1, 31);
         rs2   = $urandom_range(1, 31);
         rd    = $urandom_range(0, 31);
         op    = 4'($urandom_range(0, 15));
         bsel  = 1'($urandom_range(0, 1));
         imm12 = 12'($urandom);
         set_reg(rs1, $urandom);
         set_reg(rs2, $urandom);
         if (bsel) instr = {imm12, 5'(rs1), 3'd0, 5'(rd), OPC_IMM};
         else      instr = {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), OPC_OP};
         a = model_rf[rs1];
         b = bsel ? sext12(imm12) : model_rf[rs2];
         exp = ref_alu(op, a, b);
         load_ir(instr);
         ctl_if.alu_op = op; ctl_if.alu_b_sel = bsel; ctl_if.mem_addr_sel = 1;
         settle();
         check($sformatf("rand_alu%0d_op%0d", i, op), mem_if.addr, exp);
         a = model_rf[instr[19:15]];
         b = model_rf[instr[24:20]];
         check($sformatf("rand_eq%0d", i), 32'(ctl_if.cmp_eq), (a == b) ? 32'd1 : 32'd0);
         check($sformatf("rand_lt%0d", i), 32'(ctl_if.cmp_lt),
               ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
         check($sformatf("rand_ltu%0d", i), 32'(ctl_if.cmp_ltu), (a < b) ? 32'd1 : 32'd0);
         ctl_if.mem_addr_sel = 0;
         exec_alu(op, bsel);
         model_write(rd, exp);
         check_reg($sformatf("rand_wb%0d", i), rd, model_rf[rd]);
      end

      // Randomized loads
      for (int i = 0; i < 30; i++) begin
         size  = $urandom_range(0, 2);
         lo    = (size == 0) ? $urandom_range(0, 3) : (size == 1) ? 2 * $urandom_range(0, 1) : 0;
         uns   = (size == 2) ? 1'b0 : 1'($urandom_range(0, 1));
         rd    = $urandom_range(2, 31);
         rdata = $urandom;
         f3    = {uns, 2'(size)};
         set_reg(1, 32'h0000_0200);
         do_load({12'(lo), 5'd1, f3, 5'(rd), OPC_LOAD}, rdata, 2'(size), uns);
         model_write(rd, ref_load(rdata, lo, size, uns));
         check_reg($sformatf("rand_load%0d_s%0d_o%0d", i, size, lo), rd, model_rf[rd]);
      end

      // Randomized stores
      for (int i = 0; i < 30; i++) begin
         size = $urandom_range(0, 2);
         lo   = (size == 0) ? $urandom_range(0, 3) : (size == 1) ? 2 * $urandom_range(0, 1) : 0;
         val  = $urandom;
         set_reg(1, 32'h0000_0300);
         set_reg(2, val);
         load_ir({7'd0, 5'd2, 5'd1, 3'(size), 5'(lo), OPC_STORE});
         ctl_if.alu_b_sel = 1; ctl_if.mem_addr_sel = 1; ctl_if.mem_we = 1;
         ctl_if.mem_size = 2'(size);
         if (size == 0) begin
            sexp = 4'(1 << lo);
            wexp = (val & 32'hFF) * 32'h0101_0101;
         end else if (size == 1) begin
            sexp = 4'(3 << lo);
            wexp = (val & 32'hFFFF) * 32'h0001_0001;
         end else begin
            sexp = 4'hF;
            wexp = val;
         end
         settle();
         check($sformatf("rand_st_addr%0d", i), mem_if.addr, 32'h300 + 32'(lo));
         check($sformatf("rand_st_wstrb%0d", i), 32'(mem_if.wstrb), 32'(sexp));
         check($sformatf("rand_st_wdata%0d", i), mem_if.wdata, wexp);
         idle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Multicycle RV32I integer datapath for the core.
- An external FSM drives it through the datapath_control interface. The datapath reports decoded fields and compare flags back on the same interface.
- Holds PC, IR, a 32x32 register file, immediate generator, ALU, comparator and load/store alignment.
- Reaches memory through one memory_port interface.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, IR value after reset (addi x0,x0,0).

Ports:
- clk  input  1  core clock, all state on rising edge.
- rst_n  input  1  one clock; reset is asynchronous and active-low.
- mem_port  interface  -  memory_port, master side: addr[31:0], wdata[31:0], wstrb[3:0], we, re (out); rdata[31:0] (in).
- control  interface  -  datapath_control, datapath side:
  - In: pc_we, pc_sel[1:0], ir_we, rf_we, wb_sel[1:0], alu_a_sel, alu_b_sel, alu_op[3:0], mem_addr_sel, mem_re, mem_we, mem_size[1:0], load_unsigned.
  - Out: opcode[6:0], funct3[2:0], funct7[6:0], cmp_eq, cmp_lt, cmp_ltu.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, ir=NOP_INSTR, all 32 registers=0, latched addr low bits=0.
  - mem_port.re/we/wstrb=0 combinationally whenever mem_re/mem_we are 0.
- Decode outputs are combinational from ir: opcode=ir[6:0], funct3=ir[14:12], funct7=ir[31:25].
- Immediates are selected by ir opcode: I (loads/OP-IMM/JALR), S, B, U, J; all sign-extended.
- ALU operand A: alu_a_sel=0 selects rs1, 1 selects pc.
- ALU operand B: alu_b_sel=0 selects rs2, 1 selects imm.
- alu_op encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B. Shifts use B[4:0]; undefined codes yield 0.
- Comparator always compares rs1 vs rs2 and drives cmp_eq, cmp_lt (signed), cmp_ltu.
- Register file reads are combinational.
  - x0 always reads 0; writes to x0 are ignored.
  - Write happens on the clock edge when rf_we=1, to rd=ir[11:7].
  - A same-cycle read of the register being written returns the old value.
- Write-back mux wb_sel: 0 ALU result, 1 load data, 2 pc+4, 3 imm.
- PC next value, on the clock edge when pc_we=1:
  - pc_sel=0: pc+4.
  - pc_sel=1: ALU result.
  - pc_sel=2: ALU result & ~1.
  - pc_sel=3: pc+imm.
- IR loads mem_port.rdata on the clock edge when ir_we=1.
- Memory address: mem_addr_sel=0 selects pc, 1 selects ALU result. Byte address is presented as-is.
- Read timing: re=mem_re. rdata is valid the cycle after re; the datapath latches addr[1:0] on re for load alignment.
- Writes: we=mem_we.
  - wdata = rs2 replicated into lanes (byte x4, half x2, word).
  - wstrb by mem_size: 0 byte gives 1<<addr[1:0]; 1 half gives 3<<addr[1:0] (addr[1] only); 2 word gives 4'hF.
  - wstrb=0 when we=0.
- Load data: the selected byte/half from rdata is shifted down using the latched bits, then zero-extended if load_unsigned else sign-extended.
- Simultaneous rf_we and pc_we: both commit; write-back uses pre-edge pc.
- Reset asserted mid-instruction discards all state immediately.

Optional Feature:
- Macro DATAPATH_MISALIGN_CHECK_EN.
- When defined:
  - control gains output misaligned, asserted combinationally when mem_re/mem_we with half at odd addr or word at addr[1:0]!=0, or pc_we with next pc[1:0]!=0.
  - A misaligned store forces wstrb=0 and we=0.
- When undefined: no output; accesses proceed unchecked.

Test Plan:
- Reset: hold rst_n=0 one cycle, release, idle controls -> pc=0, opcode=7'h13, mem re=0, we=0, wstrb=0.
- Fetch: mem_addr_sel=0, mem_re=1, then ir_we=1 with rdata=32'h007302B3 (add x5,x6,x7) -> opcode=7'h33, funct3=0, funct7=0; pc_we/pc_sel=0 -> pc=4.
- ALU: x6=5, x7=7 via addi sequences, execute add (alu_op=0, rf_we, wb_sel=0) -> x5=12; sub -> 32'hFFFFFFFE; cmp_lt=1, cmp_ltu=1.
- x0: instruction with rd=0, rf_we=1, ALU result 0x55 -> x0 reads 0.
- Store/load: sb x7 (rs2=0x000000A5) at addr 0x102 -> wstrb=4'b0100, wdata=0xA5A5A5A5. lb with rdata=0x00A50000 -> 0xFFFFFFA5; lbu -> 0x000000A5.
- Jump: jalr with rs1=0x101, imm=0, pc_sel=2, wb_sel=2 from pc=0x20 -> pc=0x100, rd=0x24.
